// File: rtl/branch_resolve_unit.sv
// Branch resolution: tracks BTB predictions through ID/EX, raises redirects
// on mispredicts and drives the BTB training port from a MEM-stage slot.
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      pc_if,
    input  logic             pred_taken_if,
    input  logic [31:0]      pred_target_if,
    input  logic             stall,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_front,
    output logic [31:0]      pc_update,
    output logic [31:0]      actual_target,
    output logic             actual_taken,
    output logic             is_branch,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
    } meta_t;

    meta_t id_q, id_d, ex_q, ex_d;

    logic resolve, br_res, br_mis, alias_mis, redir;

    logic             wr_q;
    logic [31:0]      pcu_q, tgt_q;
    logic             tk_q;
    logic [CNT_W-1:0] bc_q, mc_q;

    always_comb begin
        resolve   = ex_q.v & ~stall;
        br_res    = resolve & ex_is_branch;
        br_mis    = br_res & ((ex_q.pt != ex_taken) |
                    (ex_q.pt & ex_taken & (ex_q.ptgt != ex_target)));
        alias_mis = resolve & ~ex_is_branch & ex_q.pt;
        redir     = br_mis | alias_mis;
    end

    assign redirect_valid = redir;
    assign flush_front    = redir;
    // Only a taken branch redirects to the ALU target; all else falls through.
    assign redirect_pc = !redir ? 32'd0 :
                         (ex_is_branch & ex_taken) ? ex_target :
                         ex_q.pc + 32'd4;

    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (!stall) begin
            id_d = '{v: if_valid, pc: pc_if,
                     pt: pred_taken_if, ptgt: pred_target_if};
            ex_d = id_q;
        end
        if (redir) begin
            id_d.v = 1'b0;
            ex_d.v = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 1'b0;
            pcu_q <= '0;
            tgt_q <= '0;
            tk_q  <= 1'b0;
        end else begin
            wr_q <= br_res;
            if (br_res) begin
                pcu_q <= ex_q.pc;
                tgt_q <= ex_target;
                tk_q  <= ex_taken;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q <= '0;
            mc_q <= '0;
        end else begin
            if (br_res && bc_q != '1)
                bc_q <= bc_q + 1'b1;
            if (redir && mc_q != '1)
                mc_q <= mc_q + 1'b1;
        end
    end

    assign is_branch        = wr_q;
    assign pc_update        = pcu_q;
    assign actual_target    = tgt_q;
    assign actual_taken     = tk_q;
    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: per-cycle expectations from an
// in-flight instruction queue model, compared by an independent monitor.
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_valid = 1'b0;
    logic [31:0]      pc_if = '0;
    logic             pred_taken_if = 1'b0;
    logic [31:0]      pred_target_if = '0;
    logic             stall = 1'b0;
    logic             ex_is_branch = 1'b0;
    logic             ex_taken = 1'b0;
    logic [31:0]      ex_target = '0;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_front;
    logic [31:0]      pc_update;
    logic [31:0]      actual_target;
    logic             actual_taken;
    logic             is_branch;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .pc_if(pc_if),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .stall(stall), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_front(flush_front), .pc_update(pc_update),
        .actual_target(actual_target), .actual_taken(actual_taken),
        .is_branch(is_branch), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] ptgt;
    } inst_t;

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          wr;
        logic [31:0] pcu;
        logic [31:0] tgt;
        bit          tk;
        int          bc;
        int          mc;
    } exp_t;

    // q[0] is the youngest in-flight instruction; q[1] is the one in EX
    inst_t q[$];
    exp_t  sb[$];
    bit          m_wr;
    logic [31:0] m_pcu, m_tgt;
    bit          m_tk;
    int          m_bc, m_mc;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit fv, input logic [31:0] fpc, input bit fpt,
                         input logic [31:0] ftg, input bit st, input bit eb,
                         input bit et, input logic [31:0] etg, input bit dorst);
        exp_t  e;
        inst_t n;
        bit    have, res, mis;
        @(negedge clk);
        rst = dorst;
        if_valid = fv; pc_if = fpc; pred_taken_if = fpt; pred_target_if = ftg;
        stall = st; ex_is_branch = eb; ex_taken = et; ex_target = etg;
        if (dorst) begin
            q.delete();
            m_wr = 0; m_pcu = '0; m_tgt = '0; m_tk = 0; m_bc = 0; m_mc = 0;
        end
        have = !dorst && q.size() == 2 && q[1].v;
        res  = have && !st;
        mis  = 0;
        if (res && eb)
            mis = (q[1].pt != et) || (q[1].pt && et && q[1].ptgt != etg);
        else if (res && q[1].pt)
            mis = 1;
        e.rv = mis;
        e.rpc = !mis ? 32'd0 : (eb && et) ? etg : q[1].pc + 32'd4;
        e.wr = m_wr; e.pcu = m_pcu; e.tgt = m_tgt; e.tk = m_tk;
        e.bc = m_bc; e.mc = m_mc;
        sb.push_back(e);
        if (!dorst) begin
            m_wr = res && eb;
            if (m_wr) begin
                m_pcu = q[1].pc; m_tgt = etg; m_tk = et;
                m_bc = (m_bc < MAXC) ? m_bc + 1 : MAXC;
            end
            if (mis) m_mc = (m_mc < MAXC) ? m_mc + 1 : MAXC;
            if (!st) begin
                n.v = fv; n.pc = fpc; n.pt = fpt; n.ptgt = ftg;
                q.push_front(n);
                if (q.size() > 2) void'(q.pop_back());
                if (mis) foreach (q[i]) q[i].v = 0;
            end
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit pt,
                         input logic [31:0] tg);
        cycle(1, pc, pt, tg, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic idle();
        cycle(0, 32'd0, 0, 32'd0, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic ex(input bit st, input bit eb, input bit et,
                      input logic [31:0] tg);
        cycle(0, 32'd0, 0, 32'd0, st, eb, et, tg, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
                chk("flush_front", {31'd0, flush_front}, {31'd0, e.rv});
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("is_branch", {31'd0, is_branch}, {31'd0, e.wr});
                chk("pc_update", pc_update, e.pcu);
                chk("actual_target", actual_target, e.tgt);
                chk("actual_taken", {31'd0, actual_taken}, {31'd0, e.tk});
                chk("branch_count", 32'(branch_count), 32'(e.bc));
                chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
            end
        end
    end

    initial begin : driver
        logic [31:0] r, p, t;
        bit          rs;
        cycle(0, 32'd0, 0, 32'd0, 0, 0, 0, 32'd0, 1);
        idle();
        // correct taken prediction
        fetch(32'h100, 1, 32'h200); idle(); ex(0, 1, 1, 32'h200); idle();
        // direction mispredict
        fetch(32'h40, 0, 32'h0); idle(); ex(0, 1, 1, 32'h80); idle();
        // target mispredict, then predicted-taken resolving not-taken
        fetch(32'h200, 1, 32'h300); idle(); ex(0, 1, 1, 32'h340); idle();
        fetch(32'h500, 1, 32'h600); idle(); ex(0, 1, 0, 32'h600); idle();
        // alias on a non-branch at the top of the address space
        fetch(32'hFFFF_FFFC, 1, 32'h10); idle(); ex(0, 0, 0, 32'h0); idle();
        // mispredict held in EX by stall, then released
        fetch(32'h700, 0, 32'h0); idle();
        repeat (3) ex(1, 1, 1, 32'h900);
        ex(0, 1, 1, 32'h900); idle(); idle();
        // back-to-back correctly predicted branches
        fetch(32'h800, 1, 32'h880); fetch(32'h804, 0, 32'h0);
        ex(0, 1, 1, 32'h880); ex(0, 1, 0, 32'h123); idle(); idle();
        // reset between edges while a BTB write is pending
        fetch(32'hA00, 1, 32'hB00); idle(); ex(0, 1, 1, 32'hB00);
        cycle(0, 32'd0, 0, 32'd0, 0, 0, 0, 32'd0, 1);
        idle();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            p = $urandom() & 32'hFFFF_FFFC;
            if (r[3:0] == 4'd0) p = 32'hFFFF_FFFC;
            t = $urandom() & 32'hFFFF_FFFC;
            if (r[4] && q.size() == 2) t = q[1].ptgt;
            rs = $urandom_range(0, 99) < (m_wr ? 8 : 2);
            cycle(r[5] | r[6], p, r[7], $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 4) == 0, r[8] | r[9], r[10], t, rs);
        end
        // saturation: 20 mispredicting branches with no reset in between
        cycle(0, 32'd0, 0, 32'd0, 0, 0, 0, 32'd0, 1);
        for (int i = 0; i < 20; i++) begin
            fetch(32'h2000 + 32'(i * 4), 0, 32'h0); idle();
            ex(0, 1, 1, 32'h3000);
        end
        idle();
        #3;
        chk("branch_count_sat", 32'(branch_count), 32'(MAXC));
        chk("mispredict_count_sat", 32'(mispredict_count), 32'(MAXC));
        @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks the BTB prediction made for every fetched instruction through the IF/ID and ID/EX pipeline registers. Compares each prediction against the outcome resolved in EX, and raises a front-end flush plus a PC redirect on any misprediction. Drives the BTB write (training) port from a registered MEM-stage slot. This block is the writer side of the BTB interface and sits beside the ID/EX/MEM pipeline registers.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  an instruction is fetched this cycle
- pc_if  in  32  PC of the fetched instruction
- pred_taken_if  in  1  BTB prediction for pc_if
- pred_target_if  in  32  BTB predicted target for pc_if
- stall  in  1  hold the IF/ID and ID/EX metadata registers
- ex_is_branch  in  1  instruction in EX is a conditional branch
- ex_taken  in  1  resolved branch direction (valid when ex_is_branch)
- ex_target  in  32  resolved branch target from ALU
- redirect_valid  out  1  mispredict detected in EX this cycle
- redirect_pc  out  32  correct next PC
- flush_front  out  1  kill IF/ID and ID/EX contents; equals redirect_valid
- pc_update  out  32  BTB write PC (MEM stage)
- actual_target  out  32  BTB write target
- actual_taken  out  1  BTB write direction
- is_branch  out  1  BTB write enable
- branch_count  out  CNT_W  resolved branches, saturating
- mispredict_count  out  CNT_W  redirects issued, saturating

## Operation
- Metadata record: {v, pc, pt, ptgt}. Two stages: meta_id and meta_ex.
- When stall=0, meta_id loads {if_valid, pc_if, pred_taken_if, pred_target_if}, and meta_ex loads meta_id.
- When stall=1, both stages hold.
- resolve = meta_ex.v & !stall.
- Branch mispredict, when resolve & ex_is_branch:
  - pt != ex_taken, or
  - pt & ex_taken & (ptgt != ex_target).
- Alias mispredict, when resolve & !ex_is_branch & pt: the BTB predicted taken on a non-branch.
- redirect_valid = branch mispredict | alias mispredict.
- redirect_pc:
  - branch with ex_taken=1: ex_target.
  - otherwise: meta_ex.pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- On a redirect edge, meta_id.v and meta_ex.v clear; the incoming IF instruction is wrong-path. The IF stage is killed externally by flush_front.
- MEM slot, on each edge:
  - If resolve & ex_is_branch: load pc_update=meta_ex.pc, actual_target=ex_target, actual_taken=ex_taken, is_branch=1.
  - Else: is_branch=0; the other MEM outputs hold their last value.
- Alias mispredicts never write the BTB (is_branch=0).
- Counters:
  - branch_count increments on resolve & ex_is_branch.
  - mispredict_count increments on redirect_valid.
  - Both saturate at 2^CNT_W-1.

## Timing
- Reset values: all metadata v=0; pc/target fields 0; is_branch=0, actual_taken=0, pc_update=0, actual_target=0; counters 0.
- redirect_valid, redirect_pc and flush_front are 0 during reset.
- redirect_valid, redirect_pc and flush_front are combinational from meta_ex and the EX inputs; they are valid in the same cycle the instruction is in EX.
- Fetch to resolve: an instruction sampled at edge N (IF) is in ID after N and in EX after N+1. It resolves in cycle N+1..N+2 absent stalls.
- BTB write: is_branch is high for exactly one cycle, the cycle after resolve (MEM stage).
- Stall in EX: no resolve, no redirect, and no counter change. A bubble (is_branch=0) enters MEM. The resolve occurs once, in the first unstalled cycle.
- Back-to-back branches train the BTB on consecutive cycles. The second one is only in EX if the first did not redirect.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. It also drops any pending MEM-stage write.
- is_branch=1 and redirect_valid=1 in the same cycle is legal and independent: the former belongs to the older instruction.

## Test plan
- Correct taken prediction:
  - Stimulus: fetch pc 0x100 with pt=1, ptgt=0x200; in EX drive ex_is_branch=1, ex_taken=1, ex_target=0x200.
  - Required: no redirect; the next cycle gives is_branch=1, pc_update=0x100, actual_target=0x200, actual_taken=1; branch_count=1, mispredict_count=0.
- Direction mispredict:
  - Stimulus: pc 0x40 with pt=0, resolving ex_taken=1, ex_target=0x80.
  - Required: redirect_valid=1 and redirect_pc=0x80 in EX; meta_id.v=0 and meta_ex.v=0 after the edge; mispredict_count=1.
- Target mispredict plus not-taken path:
  - Stimulus: pt=1, ptgt=0x300, resolving ex_target=0x340 → required: redirect_pc=0x340.
  - Stimulus: pc 0x500 with pt=1, resolving ex_taken=0 → required: redirect_pc=0x504.
- Alias and wrap:
  - Stimulus: non-branch at pc 0xFFFFFFFC with pt=1.
  - Required: redirect_pc=0x00000000, is_branch stays 0 the next cycle, branch_count unchanged.
- Stall:
  - Stimulus: a mispredicting branch in EX with stall=1 for 3 cycles, then released.
  - Required: redirect fires only on the release cycle; mispredict_count increments by exactly 1; is_branch pulses once.
- Reset mid-flight and saturation:
  - Stimulus: assert rst between clock edges while a MEM write is pending → required: is_branch=0 immediately.
  - Stimulus: with CNT_W=2, resolve 5 mispredicting branches → required: both counters stop at 3.
